// File: rtl/tpg_cfg_ctrl.sv
// Configuration and sequencing controller for the tpg test-pattern generator.
// Shadow timing set written over a valid/ready port, validated on commit, applied atomically.
module tpg_cfg_ctrl #(
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 12,
    parameter int TMO_BITS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    output logic              cfg_rdy,
    input  logic              commit,
    input  logic              enable,
    input  logic              vs_q,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [H_BITS-1:0] tV_END,
    output logic              tpg_rst_n,
    output logic              busy,
    output logic              cfg_err,
    output logic              tmo,
    output logic [15:0]       frame_cnt
);

    // state   | meaning
    // IDLE    | generator held in reset; accepts commit / enable
    // CHECK   | one cycle: validate the shadow set
    // PENDING | validated set waits for a frame boundary (vs rise), timeout or disable
    // APPLY   | one cycle: load active set, generator held in reset
    // RUN     | generator running, frames counted
    typedef enum logic [2:0] {IDLE, CHECK, PENDING, APPLY, RUN} state_t;

    localparam int VW = (H_BITS > V_BITS) ? H_BITS : V_BITS;
    localparam logic [TMO_BITS-1:0] TMO_ALL = '1;

    state_t state, state_nx;
    logic   ret_run, ret_run_nx;
    logic   act_vld;
    logic   vs_d;
    logic   vs_rise;
    logic   wr_acc;
    logic   chk_ok;
    logic   tmo_hit;
    logic   set_err, clr_err, set_tmo, load_act;
    logic   run_nx, busy_nx;
    logic   unused_wdata;

    logic [TMO_BITS-1:0] tmo_cnt;

    logic [H_BITS-1:0] s_hs_start, s_hs_end, s_hact_start, s_hact_end, s_h_end, s_v_end;
    logic [V_BITS-1:0] s_vs_start, s_vs_end, s_vact_start, s_vact_end;

    assign vs_rise      = vs_q & ~vs_d;
    assign wr_acc       = cfg_wr & cfg_rdy;
    assign tmo_hit      = (tmo_cnt == (TMO_ALL - TMO_BITS'(1)));
    assign unused_wdata = ^cfg_wdata;

    // V_END is H_BITS wide like the tpg port, so vertical compares use a common width.
    assign chk_ok = (s_hs_start < s_hs_end) && (s_hs_end < s_h_end)
                 && (s_hact_start < s_hact_end) && (s_hact_end <= s_h_end)
                 && (s_vs_start < s_vs_end) && (VW'(s_vs_end) <= VW'(s_v_end))
                 && (s_vact_start < s_vact_end) && (VW'(s_vact_end) <= VW'(s_v_end))
                 && (s_h_end != '0) && (s_v_end != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ret_run <= 1'b0;
        end else begin
            state   <= state_nx;
            ret_run <= ret_run_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ret_run_nx = ret_run;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        set_tmo    = 1'b0;
        load_act   = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nx   = CHECK;
                    ret_run_nx = 1'b0;
                end else if (enable) begin
                    if (act_vld) state_nx = RUN;
                    else         set_err  = 1'b1;
                end
            end
            CHECK: begin
                if (chk_ok) begin
                    clr_err  = 1'b1;
                    state_nx = ret_run ? PENDING : APPLY;
                end else begin
                    set_err  = 1'b1;
                    state_nx = ret_run ? RUN : IDLE;
                end
            end
            PENDING: begin
                if (!enable || vs_rise) begin
                    state_nx = APPLY;
                end else if (tmo_hit) begin
                    state_nx = APPLY;
                    set_tmo  = 1'b1;
                end
            end
            APPLY: begin
                load_act = 1'b1;
                state_nx = enable ? RUN : IDLE;
            end
            RUN: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (commit) begin
                    state_nx   = CHECK;
                    ret_run_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The generator keeps running while a set checked from RUN is in flight.
    always_comb begin
        run_nx  = (state_nx == RUN) || (state_nx == PENDING)
               || ((state_nx == CHECK) && ret_run_nx);
        busy_nx = (state_nx == CHECK) || (state_nx == PENDING) || (state_nx == APPLY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpg_rst_n <= 1'b0;
            busy      <= 1'b0;
            cfg_rdy   <= 1'b1;
            cfg_err   <= 1'b0;
            tmo       <= 1'b0;
            act_vld   <= 1'b0;
            vs_d      <= 1'b0;
            tmo_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            tpg_rst_n <= run_nx;
            busy      <= busy_nx;
            cfg_rdy   <= ~busy_nx;
            vs_d      <= vs_q;
            if (set_err)      cfg_err <= 1'b1;
            else if (clr_err) cfg_err <= 1'b0;
            if (set_tmo)      tmo <= 1'b1;
            else if (clr_err) tmo <= 1'b0;
            if (load_act)     act_vld <= 1'b1;
            if ((state != PENDING) && (state_nx == PENDING)) tmo_cnt <= '0;
            else if (state == PENDING)                       tmo_cnt <= tmo_cnt + TMO_BITS'(1);
            if ((state == RUN) && vs_rise) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_hs_start   <= '0;
            s_hs_end     <= '0;
            s_hact_start <= '0;
            s_hact_end   <= '0;
            s_h_end      <= '0;
            s_vs_start   <= '0;
            s_vs_end     <= '0;
            s_vact_start <= '0;
            s_vact_end   <= '0;
            s_v_end      <= '0;
        end else if (wr_acc) begin
            case (cfg_addr)
                4'd0:    s_hs_start   <= cfg_wdata[H_BITS-1:0];
                4'd1:    s_hs_end     <= cfg_wdata[H_BITS-1:0];
                4'd2:    s_hact_start <= cfg_wdata[H_BITS-1:0];
                4'd3:    s_hact_end   <= cfg_wdata[H_BITS-1:0];
                4'd4:    s_h_end      <= cfg_wdata[H_BITS-1:0];
                4'd5:    s_vs_start   <= cfg_wdata[V_BITS-1:0];
                4'd6:    s_vs_end     <= cfg_wdata[V_BITS-1:0];
                4'd7:    s_vact_start <= cfg_wdata[V_BITS-1:0];
                4'd8:    s_vact_end   <= cfg_wdata[V_BITS-1:0];
                4'd9:    s_v_end      <= cfg_wdata[H_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tHS_START   <= '0;
            tHS_END     <= '0;
            tHACT_START <= '0;
            tHACT_END   <= '0;
            tH_END      <= '0;
            tVS_START   <= '0;
            tVS_END     <= '0;
            tVACT_START <= '0;
            tVACT_END   <= '0;
            tV_END      <= '0;
        end else if (load_act) begin
            tHS_START   <= s_hs_start;
            tHS_END     <= s_hs_end;
            tHACT_START <= s_hact_start;
            tHACT_END   <= s_hact_end;
            tH_END      <= s_h_end;
            tVS_START   <= s_vs_start;
            tVS_END     <= s_vs_end;
            tVACT_START <= s_vact_start;
            tVACT_END   <= s_vact_end;
            tV_END      <= s_v_end;
        end
    end

endmodule

// File: tb/tb_tpg_cfg_ctrl.sv
// Self-checking bench for tpg_cfg_ctrl: validation table plus hand sequences for sequencing corners.
module tb_tpg_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_rdy;
    logic        commit;
    logic        enable;
    logic        vs_q;
    logic [11:0] t_hs_start, t_hs_end, t_hact_start, t_hact_end, t_h_end;
    logic [11:0] t_vs_start, t_vs_end, t_vact_start, t_vact_end, t_v_end;
    logic        tpg_rst_n, busy, cfg_err, tmo;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [9:0][15:0] f;
        logic             err;
    } vec_t;

    vec_t        vecs [12];
    logic [11:0] exp_act [10];

    tpg_cfg_ctrl #(.H_BITS(12), .V_BITS(12), .TMO_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdy(cfg_rdy),
        .commit(commit), .enable(enable), .vs_q(vs_q),
        .tHS_START(t_hs_start), .tHS_END(t_hs_end), .tHACT_START(t_hact_start),
        .tHACT_END(t_hact_end), .tH_END(t_h_end), .tVS_START(t_vs_start),
        .tVS_END(t_vs_end), .tVACT_START(t_vact_start), .tVACT_END(t_vact_end),
        .tV_END(t_v_end), .tpg_rst_n(tpg_rst_n), .busy(busy), .cfg_err(cfg_err),
        .tmo(tmo), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int a8, input int a9, input bit e);
        vec_t v;
        v.f[0] = 16'(a0); v.f[1] = 16'(a1); v.f[2] = 16'(a2); v.f[3] = 16'(a3);
        v.f[4] = 16'(a4); v.f[5] = 16'(a5); v.f[6] = 16'(a6); v.f[7] = 16'(a7);
        v.f[8] = 16'(a8); v.f[9] = 16'(a9); v.err = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic chk_act(input string tag);
        logic [11:0] act [10];
        act[0] = t_hs_start; act[1] = t_hs_end;  act[2] = t_hact_start; act[3] = t_hact_end;
        act[4] = t_h_end;    act[5] = t_vs_start; act[6] = t_vs_end;    act[7] = t_vact_start;
        act[8] = t_vact_end; act[9] = t_v_end;
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_act%0d", tag, i), {20'b0, act[i]}, {20'b0, exp_act[i]});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tpg_rst_n"}, {31'b0, tpg_rst_n}, 0);
        chk({tag, "_cfg_rdy"},   {31'b0, cfg_rdy},   1);
        chk({tag, "_busy"},      {31'b0, busy},      0);
        chk({tag, "_cfg_err"},   {31'b0, cfg_err},   0);
        chk({tag, "_tmo"},       {31'b0, tmo},       0);
        chk({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 0);
        for (int i = 0; i < 10; i++) exp_act[i] = '0;
        chk_act(tag);
    endtask

    task automatic vs_pulse();
        vs_q = 1'b1;
        tick();
        vs_q = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        //       HSs  HSe  HAs  HAe  Hend VSs  VSe  VAs  VAe  Vend err
        vecs[0]  = mk(656, 752, 0,   640, 799, 490, 492, 0,   480, 524, 0);
        vecs[1]  = mk(10,  10,  0,   640, 799, 490, 492, 0,   480, 524, 1);
        vecs[2]  = mk(10,  20,  0,   640, 799, 490, 492, 0,   480, 524, 0);
        vecs[3]  = mk(656, 752, 0,   799, 799, 490, 524, 0,   524, 524, 0);
        vecs[4]  = mk(656, 799, 0,   640, 799, 490, 492, 0,   480, 524, 1);
        vecs[5]  = mk(656, 752, 0,   640, 799, 490, 492, 0,   525, 524, 1);
        vecs[6]  = mk(656, 752, 0,   640, 799, 490, 492, 480, 480, 524, 1);
        vecs[7]  = mk(0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   1);
        vecs[8]  = mk(656, 752, 640, 640, 799, 490, 492, 0,   480, 524, 1);
        vecs[9]  = mk(656, 752, 0,   640, 799, 490, 525, 0,   480, 524, 1);
        vecs[10] = mk('hF00A, 'h0014, 0, 640, 799, 490, 492, 0,   480, 524, 0);
        vecs[11] = mk(656, 752, 0,   640, 799, 490, 492, 0,   480, 524, 0);

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        commit = 1'b0; enable = 1'b0; vs_q = 1'b0;
        #22 rst_n = 1'b1;
        chk_reset("rst");

        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("en_noset_err", {31'b0, cfg_err}, 1);
        chk("en_noset_rst", {31'b0, tpg_rst_n}, 0);

        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 10; i++) wr(4'(i), vecs[v].f[i]);
            commit = 1'b1;
            tick();
            commit = 1'b0;
            chk($sformatf("v%0d_busy_chk", v), {31'b0, busy}, 1);
            chk($sformatf("v%0d_rdy_chk", v), {31'b0, cfg_rdy}, 0);
            tick();
            tick();
            chk($sformatf("v%0d_err", v), {31'b0, cfg_err}, {31'b0, vecs[v].err});
            if (!vecs[v].err)
                for (int i = 0; i < 10; i++) exp_act[i] = vecs[v].f[i][11:0];
            chk_act($sformatf("v%0d", v));
            chk($sformatf("v%0d_idle_busy", v), {31'b0, busy}, 0);
        end

        // commit together with enable: CHECK, APPLY, then RUN
        enable = 1'b1; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("lat_apply_rst", {31'b0, tpg_rst_n}, 0);
        chk("lat_apply_busy", {31'b0, busy}, 1);
        tick();
        chk("lat_run_rst", {31'b0, tpg_rst_n}, 1);
        chk("lat_run_busy", {31'b0, busy}, 0);
        chk_act("lat");

        repeat (3) vs_pulse();
        chk("frames3", {16'b0, frame_cnt}, 3);

        // new H_END applied at the next frame boundary
        wr(4'd4, 16'd1000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("pend_busy", {31'b0, busy}, 1);
        chk("pend_rdy", {31'b0, cfg_rdy}, 0);
        chk("pend_chk_rst", {31'b0, tpg_rst_n}, 1);
        repeat (4) tick();
        chk("pend_hend_old", {20'b0, t_h_end}, 799);
        chk("pend_run_rst", {31'b0, tpg_rst_n}, 1);
        vs_q = 1'b1;
        tick();
        vs_q = 1'b0;
        chk("vs_apply_rst", {31'b0, tpg_rst_n}, 0);
        chk("vs_apply_hend", {20'b0, t_h_end}, 799);
        tick();
        exp_act[4] = 12'd1000;
        chk("vs_run_rst", {31'b0, tpg_rst_n}, 1);
        chk("vs_run_busy", {31'b0, busy}, 0);
        chk_act("vs");
        vs_pulse();
        chk("frames4", {16'b0, frame_cnt}, 4);

        // timeout with vs_q held low
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        n = 0;
        while (tpg_rst_n && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 15);
        chk("tmo_set", {31'b0, tmo}, 1);
        tick();
        chk("tmo_run_rst", {31'b0, tpg_rst_n}, 1);
        chk("tmo_sticky", {31'b0, tmo}, 1);

        // disable while pending
        wr(4'd4, 16'd900);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("tmo_clr", {31'b0, tmo}, 0);
        enable = 1'b0;
        tick();
        chk("dis_apply_rst", {31'b0, tpg_rst_n}, 0);
        chk("dis_apply_busy", {31'b0, busy}, 1);
        tick();
        exp_act[4] = 12'd900;
        chk("dis_idle_busy", {31'b0, busy}, 0);
        chk("dis_idle_rst", {31'b0, tpg_rst_n}, 0);
        chk_act("dis");
        tick();
        chk("dis_idle_rst2", {31'b0, tpg_rst_n}, 0);

        // failing commit from RUN, then disable beating commit
        enable = 1'b1;
        tick();
        wr(4'd1, 16'd656);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("runfail_err", {31'b0, cfg_err}, 1);
        chk("runfail_rst", {31'b0, tpg_rst_n}, 1);
        chk("runfail_busy", {31'b0, busy}, 0);
        chk_act("runfail");
        enable = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("discom_busy", {31'b0, busy}, 0);
        chk("discom_rst", {31'b0, tpg_rst_n}, 0);
        tick();
        chk("discom_busy2", {31'b0, busy}, 0);

        // out-of-range address is discarded
        wr(4'd1, 16'd752);
        wr(4'd12, 16'd5);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        chk("addr12_err", {31'b0, cfg_err}, 0);
        chk_act("addr12");

        // reset in the middle of PENDING
        enable = 1'b1; commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("pre_rst_busy", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        enable = 1'b0;
        #2 rst_n = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        chk("lost_shadow_err", {31'b0, cfg_err}, 1);
        chk_act("lost");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tpg_cfg_ctrl.md
Name: tpg_cfg_ctrl

Overview:
- Configuration and sequencing controller for the tpg test-pattern generator.
- Holds shadow copies of the ten tpg timing fields, written through a valid/ready register port, and validates them on commit.
- Applies a validated set atomically: at a frame boundary while the generator runs, or immediately while it is stopped.
- Drives the generator's reset to start, stop and cleanly restart it, and counts frames.

Parameters:
H_BITS, 12, width of horizontal timing fields; also the width of tV_END, matching the tpg port.
V_BITS, 12, width of vertical timing fields tVS_START, tVS_END, tVACT_START, tVACT_END.
TMO_BITS, 24, width of the frame-boundary wait timeout counter.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
cfg_wr  in  1  shadow write request.
cfg_addr  in  4  shadow index: 0 HS_START, 1 HS_END, 2 HACT_START, 3 HACT_END, 4 H_END, 5 VS_START, 6 VS_END, 7 VACT_START, 8 VACT_END, 9 V_END.
cfg_wdata  in  16  write data, LSB-aligned and truncated to the field width.
cfg_rdy  out  1  write accepted when cfg_wr && cfg_rdy.
commit  in  1  single-cycle request to validate and apply the shadow set.
enable  in  1  level; run the generator.
vs_q  in  1  vsync from the tpg.
tHS_START..tV_END  out  H_BITS/V_BITS  active timing set, wired to the tpg inputs.
tpg_rst_n  out  1  registered active-low reset to the tpg.
busy  out  1  high in CHECK, PENDING or APPLY.
cfg_err  out  1  sticky validation failure; cleared by the next commit that passes.
tmo  out  1  sticky flag: an apply was forced by timeout; cleared by the next commit.
frame_cnt  out  16  count of vs_q rising edges seen in RUN; wraps.

Behaviour:
- Reset values:
  - state IDLE; shadow and active fields 0; act_vld 0.
  - tpg_rst_n 0, cfg_rdy 1, busy 0, cfg_err 0, tmo 0, frame_cnt 0.
  - vs_d (registered vs_q) 0; timeout counter 0.
- Shadow write: on cfg_wr && cfg_rdy, shadow[cfg_addr] takes cfg_wdata on that edge.
  - cfg_addr 10..15: write accepted (ready honoured), data discarded.
  - cfg_rdy = 0 in CHECK, PENDING and APPLY, so the shadow set is frozen while busy.
- vs rise = vs_q && !vs_d.
- States: IDLE, CHECK, PENDING, APPLY, RUN.
- IDLE (tpg_rst_n 0):
  - commit -> CHECK, with return target IDLE.
  - else enable && act_vld -> RUN.
  - enable && !act_vld -> stay in IDLE and set cfg_err.
- CHECK (one cycle). The shadow set passes only if all of these hold:
  - HS_START < HS_END < H_END;
  - HACT_START < HACT_END <= H_END;
  - VS_START < VS_END <= V_END;
  - VACT_START < VACT_END <= V_END;
  - H_END != 0 and V_END != 0.
  - Comparisons are unsigned at field width; V_END is compared zero-extended.
  - Fail: set cfg_err, leave active regs unchanged, return to the origin state.
  - Pass: clear cfg_err and tmo. Origin IDLE -> APPLY. Origin RUN -> PENDING.
- PENDING (tpg still running):
  - vs rise -> APPLY.
  - Timeout counter increments each cycle; reaching all-ones -> set tmo, go to APPLY.
  - enable low -> APPLY, then IDLE.
- APPLY (one cycle):
  - Active regs load the shadow set; act_vld set.
  - tpg_rst_n 0 for this cycle so the generator restarts at x = y = 0.
  - Next state RUN if enable is high, else IDLE.
- RUN (tpg_rst_n 1):
  - enable low -> IDLE; tpg_rst_n is 0 from the next cycle.
  - commit -> CHECK.
  - frame_cnt increments on each vs rise.
- Timeout counter clears on entry to PENDING.
- commit while busy is ignored.
- Simultaneous enable-low and commit in RUN: disable wins; commit dropped.
- tpg_rst_n and all outputs are registered; no combinational path from inputs to outputs.
- Latency from a commit at edge k in IDLE:
  - CHECK during cycle k+1; APPLY active at edge k+2.
  - Active regs are visible after edge k+2.
- Reset mid-operation: every state returns to its reset value; shadow contents are lost.

Test Plan:
- Write a valid 800x525-style set (H_END=799, V_END=524, others ordered), commit in IDLE, then raise enable -> active regs match the shadow after 2 cycles; tpg_rst_n rises 1 cycle after APPLY; cfg_err=0.
- Write HS_END=HS_START=10, commit -> cfg_err=1, active regs unchanged, state back to IDLE; then fix HS_END=20 and commit -> cfg_err=0.
- In RUN, write a new H_END and commit -> busy=1, cfg_rdy=0, active regs unchanged until the cycle after a vs rise; tpg_rst_n low exactly 1 cycle; frame_cnt keeps counting.
- In PENDING with vs_q held low and TMO_BITS=4 -> forced APPLY after 15 cycles; tmo=1.
- Drop enable during PENDING -> APPLY then IDLE; tpg_rst_n stays 0; active = new set.
- Write to addr 12 and assert rst_n low mid-PENDING -> no field changed by the write; after reset all outputs are at reset values and frame_cnt=0.
